// File: rtl/imem_boot_loader.sv
// IMEM boot loader: streams an image into IMEM, holds the core in reset, then hands the bus to the core.
// Optional running checksum of the loaded words is built when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_boot_loader #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int HOLD_CYC = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [ADDR_W-1:0] core_imem_addr,
  output logic              core_reset,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              err_trunc,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]        HOLD_INIT = 8'(HOLD_CYC - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [7:0]        hold_q;
  logic              err_q;
  logic              core_reset_q;
  logic              load_ready_q;
  logic              busy_q;
  logic              beat;
  logic              at_end;
  logic              restart;

  assign beat    = (state_q == LOAD) & load_valid;
  assign at_end  = (addr_q == LAST_ADDR);
  // A start request is only honoured outside LOAD, so a start coinciding with the last beat is dropped.
  assign restart = load_start & (state_q != LOAD);

  always_comb begin
    wcnt_d = wcnt_q;
    if (beat && (wcnt_q != DEPTH_CNT)) wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wcnt_q       <= '0;
      hold_q       <= '0;
      err_q        <= 1'b0;
      core_reset_q <= 1'b1;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else if (restart) begin
      state_q      <= LOAD;
      addr_q       <= '0;
      wcnt_q       <= '0;
      err_q        <= 1'b0;
      core_reset_q <= 1'b1;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          if (beat) begin
            addr_q <= addr_q + 1'b1;
            wcnt_q <= wcnt_d;
            if (load_last || at_end) begin
              state_q      <= HOLD;
              load_ready_q <= 1'b0;
              hold_q       <= HOLD_INIT;
              err_q        <= ~load_last;
            end
          end
        end
        HOLD: begin
          if (hold_q == 8'd0) begin
            state_q      <= RUN;
            core_reset_q <= 1'b0;
            busy_q       <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)       csum_q <= '0;
    else if (restart) csum_q <= '0;
    else if (beat)    csum_q <= csum_q + load_data;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign core_reset = core_reset_q;
  assign word_count = wcnt_q;
  assign err_trunc  = err_q;
  assign mem_wr     = ~beat;
  assign mem_wdata  = load_data;
  assign mem_addr   = (state_q == RUN)  ? core_imem_addr :
                      (state_q == LOAD) ? addr_q : '0;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: vector table for the basic load/run flow plus hand-written corner sequences.
module tb_imem_boot_loader;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 256;
  localparam int HOLD_CYC = 4;

  logic              CLK = 1'b0;
  logic              reset;
  logic              load_start;
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic [ADDR_W-1:0] core_imem_addr;
  logic              core_reset;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic [ADDR_W:0]   word_count;
  logic              err_trunc;
  logic [DATA_W-1:0] checksum;

  int checks = 0;
  int errors = 0;

  imem_boot_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .CLK(CLK), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .core_imem_addr(core_imem_addr),
    .core_reset(core_reset), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .word_count(word_count), .err_trunc(err_trunc), .checksum(checksum)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic              start;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic [ADDR_W-1:0] caddr;
    logic              e_ready;
    logic              e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic              e_creset;
    logic              e_busy;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [DATA_W-1:0] exp_ck(input logic [DATA_W-1:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    return s;
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_run(input string nm);
    int n = 0;
    while (core_reset !== 1'b0 && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk(nm, core_reset, 1'b0);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    load_start = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] sum;
    int bad;

    //           start valid data        last caddr  rdy wr addr   crst busy
    vecs[0] = '{1'b1, 1'b0, 32'h0,     1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h13,    1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h93,    1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 32'h113,   1'b1, 8'h00, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h0,     1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h0,     1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0,     1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h0,     1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 32'h0,     1'b0, 8'h2A, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 32'h0,     1'b0, 8'h05, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0};

    reset          = 1'b0;
    load_start     = 1'b0;
    load_valid     = 1'b0;
    load_data      = '0;
    load_last      = 1'b0;
    core_imem_addr = '0;

    repeat (2) @(negedge CLK);
    #1;
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_load_ready", load_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b1);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_word_count", word_count, 9'd0);
    chk("rst_err_trunc", err_trunc, 1'b0);
    chk("rst_checksum", checksum, 32'h0);
    @(negedge CLK);
    reset = 1'b1;

    // Basic load of three words, hold, then run with address pass-through.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      load_start     = vecs[i].start;
      load_valid     = vecs[i].valid;
      load_data      = vecs[i].data;
      load_last      = vecs[i].last;
      core_imem_addr = vecs[i].caddr;
      #1;
      chk($sformatf("v%0d_load_ready", i), load_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_mem_wr", i), mem_wr, vecs[i].e_wr);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_core_reset", i), core_reset, vecs[i].e_creset);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      if (!vecs[i].e_wr) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].data);
    end
    chk("t1_word_count", word_count, 9'd3);
    chk("t1_err_trunc", err_trunc, 1'b0);
    chk("t1_checksum", checksum, exp_ck(32'h1B9));

    // Full-depth image without load_last: truncation.
    pulse_start();
    chk("t3_core_reset_before_edge", core_reset, 1'b0);
    sum = '0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CLK);
      load_start = 1'b0;
      load_valid = 1'b1;
      load_last  = 1'b0;
      load_data  = 32'(i * 3 + 1);
      #1;
      if (mem_wr !== 1'b0 || mem_addr !== ADDR_W'(i) || load_ready !== 1'b1) bad++;
      sum = sum + load_data;
    end
    chk("t3_bad_beats", bad, 0);
    @(negedge CLK);
    load_valid = 1'b0;
    #1;
    chk("t3_err_trunc", err_trunc, 1'b1);
    chk("t3_word_count", word_count, 9'd256);
    chk("t3_load_ready", load_ready, 1'b0);
    chk("t3_busy_hold", busy, 1'b1);
    chk("t3_core_reset_hold", core_reset, 1'b1);
    chk("t3_checksum", checksum, exp_ck(sum));
    wait_run("t3_reach_run");

    // Reload from RUN with a single word.
    pulse_start();
    chk("t5_core_reset_before_edge", core_reset, 1'b0);
    @(negedge CLK);
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'h7;
    load_last  = 1'b1;
    #1;
    chk("t5_core_reset_after_start", core_reset, 1'b1);
    chk("t5_err_cleared", err_trunc, 1'b0);
    chk("t5_word_count_cleared", word_count, 9'd0);
    chk("t5_mem_addr", mem_addr, 8'h00);
    chk("t5_mem_wr", mem_wr, 1'b0);
    @(negedge CLK);
    load_valid = 1'b0;
    load_last  = 1'b0;
    #1;
    chk("t5_word_count", word_count, 9'd1);
    chk("t5_err_trunc", err_trunc, 1'b0);
    chk("t5_checksum", checksum, exp_ck(32'h7));
    wait_run("t5_reach_run");

    // Valid gap mid-image, with a stray load_start inside LOAD.
    pulse_start();
    @(negedge CLK);
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'h100;
    #1;
    chk("t4_addr0", mem_addr, 8'h00);
    @(negedge CLK);
    load_data = 32'h200;
    #1;
    chk("t4_addr1", mem_addr, 8'h01);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      load_valid = 1'b0;
      load_start = (i == 2);
      #1;
      if (load_ready !== 1'b1 || mem_wr !== 1'b1) bad++;
    end
    chk("t4_gap_bad", bad, 0);
    @(negedge CLK);
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'h300;
    load_last  = 1'b1;
    #1;
    chk("t4_addr2", mem_addr, 8'h02);
    chk("t4_wr2", mem_wr, 1'b0);
    @(negedge CLK);
    load_valid = 1'b0;
    load_last  = 1'b0;
    #1;
    chk("t4_word_count", word_count, 9'd3);
    chk("t4_checksum", checksum, exp_ck(32'h600));
    wait_run("t4_reach_run");

    // Reset asserted in the middle of a load.
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data  = 32'(32'hA0 + i);
    end
    @(negedge CLK);
    reset = 1'b0;
    #1;
    chk("t6_mem_wr", mem_wr, 1'b1);
    chk("t6_core_reset", core_reset, 1'b1);
    chk("t6_word_count", word_count, 9'd0);
    chk("t6_mem_addr", mem_addr, 8'h00);
    chk("t6_busy", busy, 1'b0);
    chk("t6_checksum", checksum, 32'h0);
    @(negedge CLK);
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    chk("t6_idle_ready", load_ready, 1'b0);
    chk("t6_idle_mem_wr", mem_wr, 1'b1);
    chk("t6_idle_busy", busy, 1'b0);
    chk("t6_idle_core_reset", core_reset, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
